// File: rtl/reg_file_ctrl.sv
// ============================================================================
// Module      : reg_file_ctrl
// Description : Sequencer that expands register-file operations into ordered
//               single-cycle strobes for the accumulator, X/Y, SP and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_ctrl #(
    parameter int             AW       = 16,
    parameter logic [AW-1:0]  SP_EMPTY = 16'h03FF,
    parameter logic [AW-1:0]  SP_FULL  = 16'h0200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic          reg_sel,
    input  logic [AW-1:0] addr_in,
    input  logic [AW-1:0] sp_in,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          str_rez,
    output logic          load_x,
    output logic          load_y,
    output logic          acc_opx,
    output logic          acc_opy,
    output logic          push,
    output logic          pop,
    output logic          dm_re,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic          wdata_sel
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S1   = 3'd1;
    localparam logic [2:0] ST_S2   = 3'd2;
    localparam logic [2:0] ST_S3   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [3:0] c_OP_NOP      = 4'd0;
    localparam logic [3:0] c_OP_LOAD     = 4'd1;
    localparam logic [3:0] c_OP_MOVE     = 4'd2;
    localparam logic [3:0] c_OP_ALU      = 4'd3;
    localparam logic [3:0] c_OP_PUSH     = 4'd4;
    localparam logic [3:0] c_OP_POP      = 4'd5;
    localparam logic [3:0] c_OP_ALU_MOVE = 4'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [3:0]    r_op;
    logic          r_sel;
    logic [AW-1:0] r_addr;
    logic          r_err;

    logic          w_accept;
    logic          w_refused;
    logic          w_fault;
    logic          w_load;
    logic          w_acc;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_refused = ((r_op == c_OP_PUSH) && (sp_in == SP_FULL)) ||
                       ((r_op == c_OP_POP)  && (sp_in == SP_EMPTY));
    // Bounds and legality are only judged in the first cycle after acceptance.
    assign w_fault   = (r_state == ST_S1) && ((r_op > c_OP_ALU_MOVE) || w_refused);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_sel   <= 1'b0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op   <= op;
                r_sel  <= reg_sel;
                r_addr <= addr_in;
                r_err  <= 1'b0;
            end else if (w_fault) begin
                r_err  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = w_accept ? ST_S1 : ST_IDLE;
            ST_S1: begin
                case (r_op)
                    c_OP_ALU, c_OP_MOVE:      w_next = ST_DONE;
                    c_OP_ALU_MOVE, c_OP_LOAD: w_next = ST_S2;
                    c_OP_PUSH, c_OP_POP:      w_next = w_refused ? ST_IDLE : ST_S2;
                    default:                  w_next = ST_IDLE;
                endcase
            end
            ST_S2:   w_next = (r_op == c_OP_POP) ? ST_S3 : ST_DONE;
            ST_S3:   w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = 1'b0;
        str_rez   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        dm_re     = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        wdata_sel = 1'b0;
        w_load    = 1'b0;
        w_acc     = 1'b0;
        case (r_state)
            ST_S1: begin
                case (r_op)
                    c_OP_NOP:      done = 1'b1;
                    c_OP_ALU:      str_rez = 1'b1;
                    c_OP_ALU_MOVE: str_rez = 1'b1;
                    c_OP_MOVE: begin
                        w_load = 1'b1;
                        w_acc  = 1'b1;
                    end
                    c_OP_LOAD: begin
                        dm_re   = 1'b1;
                        dm_addr = r_addr;
                    end
                    c_OP_PUSH: begin
                        if (w_refused) begin
                            done = 1'b1;
                        end else begin
                            dm_we     = 1'b1;
                            dm_addr   = sp_in;
                            wdata_sel = r_sel;
                        end
                    end
                    c_OP_POP: begin
                        if (w_refused) begin
                            done = 1'b1;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                    default: done = 1'b1;
                endcase
            end
            ST_S2: begin
                case (r_op)
                    c_OP_ALU_MOVE: begin
                        w_load = 1'b1;
                        w_acc  = 1'b1;
                    end
                    c_OP_LOAD: w_load = 1'b1;
                    c_OP_PUSH: push = 1'b1;
                    c_OP_POP: begin
                        // SP was incremented by the pop strobe, so sp_in now names the top slot.
                        dm_re   = 1'b1;
                        dm_addr = sp_in;
                    end
                    default: ;
                endcase
            end
            ST_S3:   w_load = (r_op == c_OP_POP);
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        load_x  = w_load & ~r_sel;
        load_y  = w_load &  r_sel;
        acc_opx = load_x & w_acc;
        acc_opy = load_y & w_acc;
        error   = r_err | w_fault;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_ctrl.sv
// ============================================================================
// Module      : tb_reg_file_ctrl
// Description : Scoreboard bench for reg_file_ctrl with a per-operation trace model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        error;
        logic        str_rez;
        logic        load_x;
        logic        load_y;
        logic        acc_opx;
        logic        acc_opy;
        logic        push;
        logic        pop;
        logic        dm_re;
        logic        dm_we;
        logic        wdata_sel;
        logic [15:0] dm_addr;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic        reg_sel = 1'b0;
    logic [15:0] addr_in = '0;
    logic [15:0] sp_in = 16'h03FF;
    logic        busy, done, error, str_rez, load_x, load_y, acc_opx, acc_opy;
    logic        push, pop, dm_re, dm_we, wdata_sel;
    logic [15:0] dm_addr;

    out_t        exp_q[$];
    out_t        tr_q[$];
    logic [15:0] sp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        last_err = 1'b0;

    reg_file_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .reg_sel(reg_sel),
        .addr_in(addr_in), .sp_in(sp_in), .busy(busy), .done(done), .error(error),
        .str_rez(str_rez), .load_x(load_x), .load_y(load_y), .acc_opx(acc_opx),
        .acc_opy(acc_opy), .push(push), .pop(pop), .dm_re(dm_re), .dm_we(dm_we),
        .dm_addr(dm_addr), .wdata_sel(wdata_sel)
    );

    always #5 clk = ~clk;

    function automatic out_t busy_cycle();
        out_t e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic out_t done_cycle(input logic err);
        out_t e = busy_cycle();
        e.done  = 1'b1;
        e.error = err;
        return e;
    endfunction

    function automatic out_t load_cycle(input logic sel, input logic from_acc);
        out_t e = busy_cycle();
        if (sel) begin
            e.load_y  = 1'b1;
            e.acc_opy = from_acc;
        end else begin
            e.load_x  = 1'b1;
            e.acc_opx = from_acc;
        end
        return e;
    endfunction

    // Expected per-cycle outputs from T1 to the done cycle, plus the SP the register file shows each cycle.
    task automatic build_trace(input logic [3:0] o, input logic sel, input logic [15:0] addr,
                               input logic [15:0] sp);
        out_t e;
        tr_q.delete();
        sp_q.delete();
        if (o > 4'd6 || (o == 4'd4 && sp == 16'h0200) || (o == 4'd5 && sp == 16'h03FF)) begin
            tr_q.push_back(done_cycle(1'b1));
            sp_q.push_back(sp);
            return;
        end
        case (o)
            4'd1: begin
                e = busy_cycle(); e.dm_re = 1'b1; e.dm_addr = addr;
                tr_q.push_back(e);
                tr_q.push_back(load_cycle(sel, 1'b0));
            end
            4'd2: tr_q.push_back(load_cycle(sel, 1'b1));
            4'd3: begin
                e = busy_cycle(); e.str_rez = 1'b1;
                tr_q.push_back(e);
            end
            4'd4: begin
                e = busy_cycle(); e.dm_we = 1'b1; e.dm_addr = sp; e.wdata_sel = sel;
                tr_q.push_back(e);
                e = busy_cycle(); e.push = 1'b1;
                tr_q.push_back(e);
            end
            4'd5: begin
                e = busy_cycle(); e.pop = 1'b1;
                tr_q.push_back(e);
                e = busy_cycle(); e.dm_re = 1'b1; e.dm_addr = sp + 16'd1;
                tr_q.push_back(e);
                tr_q.push_back(load_cycle(sel, 1'b0));
            end
            4'd6: begin
                e = busy_cycle(); e.str_rez = 1'b1;
                tr_q.push_back(e);
                tr_q.push_back(load_cycle(sel, 1'b1));
            end
            default: ;
        endcase
        tr_q.push_back(done_cycle(1'b0));
        for (int k = 0; k < tr_q.size(); k++) begin
            if (o == 4'd5 && k >= 1)      sp_q.push_back(sp + 16'd1);
            else if (o == 4'd4 && k >= 2) sp_q.push_back(sp - 16'd1);
            else                          sp_q.push_back(sp);
        end
    endtask

    // abort_at > 0 asserts reset during that cycle; spam keeps start high while busy.
    task automatic do_op(input logic [3:0] o, input logic sel, input logic [15:0] addr,
                         input logic [15:0] sp, input int abort_at, input logic spam);
        int len;
        @(negedge clk);
        op = o; reg_sel = sel; addr_in = addr; sp_in = sp; start = 1'b1;
        build_trace(o, sel, addr, sp);
        len = tr_q.size();
        @(posedge clk);
        #1;
        for (int k = 0; k < len; k++) begin
            if (abort_at == 0 || k < abort_at) exp_q.push_back(tr_q[k]);
        end
        for (int k = 1; k <= len; k++) begin
            sp_in   = sp_q[k-1];
            start   = spam ? 1'b1 : 1'($urandom_range(0, 1));
            op      = 4'($urandom);
            reg_sel = 1'($urandom);
            addr_in = 16'($urandom);
            if (k == abort_at) reset = 1'b1;
            @(posedge clk);
            #1;
            if (k == abort_at) begin
                reset = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        out_t act;
        out_t exp;
        if (mon_en) begin
            act = {busy, done, error, str_rez, load_x, load_y, acc_opx, acc_opy,
                   push, pop, dm_re, dm_we, wdata_sel, dm_addr};
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
            end else begin
                exp = '0;
                exp.error = last_err;
            end
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, exp);
            end
            last_err = reset ? 1'b0 : exp.error;
        end
    end

    function automatic logic [15:0] pick_sp();
        case ($urandom_range(0, 4))
            0: return 16'h0200;
            1: return 16'h0201;
            2: return 16'h03FE;
            3: return 16'h03FF;
            default: return 16'($urandom_range(16'h0201, 16'h03FE));
        endcase
    endfunction

    initial begin
        logic [3:0] ro;
        int         bound;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        do_op(4'd2, 1'b1, 16'h1234, 16'h03FF, 0, 1'b0);
        do_op(4'd1, 1'b0, 16'h0040, 16'h03FF, 0, 1'b0);
        do_op(4'd4, 1'b0, 16'h0000, 16'h03FF, 0, 1'b0);
        do_op(4'd5, 1'b1, 16'h0000, 16'h03FE, 0, 1'b0);
        do_op(4'd5, 1'b0, 16'h0000, 16'h03FF, 0, 1'b0);
        do_op(4'd4, 1'b1, 16'h0000, 16'h0200, 0, 1'b0);
        do_op(4'd0, 1'b0, 16'h0000, 16'h0300, 0, 1'b0);
        do_op(4'hB, 1'b0, 16'h0000, 16'h0300, 0, 1'b0);
        do_op(4'd6, 1'b1, 16'h0000, 16'h0300, 0, 1'b1);
        do_op(4'd4, 1'b1, 16'h0000, 16'h0300, 0, 1'b0);
        do_op(4'd5, 1'b1, 16'h0000, 16'h0300, 2, 1'b0);
        do_op(4'd3, 1'b0, 16'h0000, 16'h0300, 0, 1'b0);
        do_op(4'd2, 1'b0, 16'h0000, 16'h0300, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            ro = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
            do_op(ro, 1'($urandom), 16'($urandom), pick_sp(), 0, 1'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        bound = 0;
        while (exp_q.size() > 0 && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
